arb_mux: RTL



---
 rtl/arb_mux_pkg.sv | 37 +++
 rtl/arb_mux_rr_arbiter.sv | 32 +++
 rtl/arb_mux.sv | 110 +++++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_pkg
//  Description : State encoding and round-robin pick helper for arb_mux.
//  Revision    : 1.0
// ============================================================================
package arb_mux_pkg;

    localparam int C_MAX_CH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FULL   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // First set request above ptr, wrapping at n; returns 0 when nothing is set.
    function automatic int unsigned rr_pick(input logic [C_MAX_CH-1:0] req,
                                            input logic [3:0]          ptr,
                                            input int                  n);
        int unsigned win;
        logic        found;
        int          idx;
        win   = 0;
        found = 1'b0;
        for (int i = 1; i <= C_MAX_CH; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && i <= n && req[idx[3:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker, one-hot grant plus index.
//  Revision    : 1.0
// ============================================================================
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     idx
);

    logic w_any;

    assign w_any = |req;
    assign idx   = SELW'(rr_pick(C_MAX_CH'(req), 4'(ptr), CHANNELS));

    always_comb begin
        grant = '0;
        if (w_any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : Registered N-to-1 bus mux with round-robin arbitration and a
//                valid/ready output stage. Optional owner lock: ARB_MUX_LOCK_EN.
//  Revision    : 1.0
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
`ifdef ARB_MUX_LOCK_EN
    input  logic                      lock,
`endif
    output logic [CHANNELS-1:0]       grant,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SELW-1:0]           out_idx,
    input  logic                      out_ready
);

    state_t              r_state;
    logic [WIDTH-1:0]    r_out;
    logic [SELW-1:0]     r_idx;
    logic [SELW-1:0]     r_ptr;

    logic [CHANNELS-1:0] w_req_eff;
    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_idx;
    logic [WIDTH-1:0]    w_word;
    logic                w_free;
    logic                w_load;
    logic                w_valid_nxt;
    state_t              w_state_nxt;

`ifdef ARB_MUX_LOCK_EN
    logic                r_valid;
    logic [SELW-1:0]     r_owner;

    // The LOCKED state does not imply a held word, so validity is tracked apart.
    assign out_valid = r_valid;
    assign w_req_eff = (r_state == ST_LOCKED) ? (req & (CHANNELS'(1) << r_owner)) : req;
    assign w_state_nxt = (lock && (r_state == ST_LOCKED || w_load)) ? ST_LOCKED
                       : (w_valid_nxt ? ST_FULL : ST_IDLE);
`else
    assign out_valid   = (r_state == ST_FULL);
    assign w_req_eff   = req;
    assign w_state_nxt = w_valid_nxt ? ST_FULL : ST_IDLE;
`endif

    assign w_free      = !out_valid || out_ready;
    assign w_load      = w_free && (|w_req_eff);
    assign w_valid_nxt = w_load || (out_valid && !out_ready);
    assign grant       = (w_load && rst_n) ? w_grant : '0;
    assign out         = r_out;
    assign out_idx     = r_idx;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req   (w_req_eff),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    always_comb begin
        w_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_idx == SELW'(k)) begin
                w_word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_idx   <= '0;
            r_ptr   <= SELW'(CHANNELS - 1);
`ifdef ARB_MUX_LOCK_EN
            r_valid <= 1'b0;
            r_owner <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef ARB_MUX_LOCK_EN
            r_valid <= w_valid_nxt;
            if (w_load && r_state != ST_LOCKED && lock) begin
                r_owner <= w_idx;
            end
`endif
            if (w_load) begin
                r_out <= w_word;
                r_idx <= w_idx;
                r_ptr <= w_idx;
            end
        end
    end

endmodule
`default_nettype wire
